// File: rtl/register_file_mp_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
// No logic, no latency; nothing here carries flow control.
package regfile_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Read/write/issue/clear bundle between a pipeline and the register file.
// Reads are combinational, writes land on the next edge; no backpressure besides ready.
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = rf_aw(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                clr_req;
  logic                ready;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_addr, clr_req,
    input  rdata, rbusy, ready
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_addr, clr_req,
    output rdata, rbusy, ready
  );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register pending-write bits: issue sets, write-back clears, flush wipes all.
// Lookups show the registered state (pre-update); updates take effect next edge.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              set_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [NWR-1:0]    clr_i,
  input  logic [NWR*AW-1:0] clr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // Set is applied after the clears so a newly issued producer stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (clr_i[j]) busy_d[clr_addr_i[j*AW +: AW]] = 1'b0;
      end
      if (set_i) busy_d[set_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      busy_o[i] = busy_q[rd_addr_i[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with x0=0, optional write bypass and hazard scoreboard.
// Reads combinational, writes visible next cycle; unusable (ready=0) for NREGS cycles during a clear sweep.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  register_file_mp_if.slave  bus
);

  localparam int AW = rf_aw(NREGS);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              run;
  logic              wr_ok;
  logic              sweep_we;
  logic [NRD-1:0]    sb_busy;
  logic [XLEN-1:0]   mem_q [NREGS];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.clr_req) begin
      state_d = RF_INIT;
      cnt_d   = '0;
    end else if (state_q == RF_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = RF_RUN;
        cnt_d   = '0;
      end
    end
  end

  // A clear request drops any write or issue presented in the same cycle.
  always_comb begin
    run       = (state_q == RF_RUN);
    wr_ok     = run && !bus.clr_req;
    sweep_we  = (state_q == RF_INIT);
    bus.ready = run;
  end

  // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && (bus.waddr[j*AW +: AW] != '0)) begin
          mem_q[bus.waddr[j*AW +: AW]] <= bus.wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && (bus.raddr[i*AW +: AW] != '0)) begin
        bus.rdata[i*XLEN +: XLEN] = mem_q[bus.raddr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_ok && bus.we[j] && (bus.waddr[j*AW +: AW] == bus.raddr[i*AW +: AW])) begin
              bus.rdata[i*XLEN +: XLEN] = bus.wdata[j*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (reset_n_i),
    .flush_i    (bus.clr_req),
    .set_i      (wr_ok && bus.iss_valid),
    .set_addr_i (bus.iss_addr),
    .clr_i      (bus.we & {NWR{wr_ok}}),
    .clr_addr_i (bus.waddr),
    .rd_addr_i  (bus.raddr),
    .busy_o     (sb_busy)
  );

  assign bus.rbusy = run ? sb_busy : '0;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: one file with bypass, one without, fed identical stimulus.
// Expected values are hand-derived constants checked with immediate assertions.
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2)) bus_b ();
  register_file_mp_if #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2)) bus_n ();

  assign bus_n.raddr     = bus_b.raddr;
  assign bus_n.we        = bus_b.we;
  assign bus_n.waddr     = bus_b.waddr;
  assign bus_n.wdata     = bus_b.wdata;
  assign bus_n.iss_valid = bus_b.iss_valid;
  assign bus_n.iss_addr  = bus_b.iss_addr;
  assign bus_n.clr_req   = bus_b.clr_req;

  register_file_mp #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus_b)
  );

  register_file_mp #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_b.we        = '0;
    bus_b.waddr     = '0;
    bus_b.wdata     = '0;
    bus_b.iss_valid = 1'b0;
    bus_b.iss_addr  = '0;
    bus_b.clr_req   = 1'b0;
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    bus_b.we[port]              = 1'b1;
    bus_b.waddr[port*AW +: AW]  = a;
    bus_b.wdata[port*XL +: XL]  = d;
  endtask

  task automatic rd(input int port, input logic [4:0] a);
    bus_b.raddr[port*AW +: AW] = a;
  endtask

  task automatic iss(input logic [4:0] a);
    bus_b.iss_valid = 1'b1;
    bus_b.iss_addr  = a;
  endtask

  function automatic logic [31:0] rdat(input int dut, input int port);
    return (dut == 0) ? bus_b.rdata[port*XL +: XL] : bus_n.rdata[port*XL +: XL];
  endfunction

  // Expects ready low for exactly 32 cycles from now, then high.
  task automatic sweep_check(input string tag);
    for (int c = 0; c < NR; c++) begin
      chk($sformatf("%s_ready_c%0d", tag, c), 32'(bus_b.ready), 32'd0);
      tick();
    end
    chk({tag, "_ready_b_done"}, 32'(bus_b.ready), 32'd1);
    chk({tag, "_ready_n_done"}, 32'(bus_n.ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_b.raddr = '0;
    idle();
    repeat (3) tick();

    rd(0, 5'd1);
    #1;
    chk("rst_ready", 32'(bus_b.ready), 32'd0);
    chk("rst_rbusy", 32'(bus_b.rbusy), 32'd0);
    chk("rst_rdata", rdat(0, 0), 32'd0);

    // Sweep after reset release, with every register hammered by ignored writes/issues.
    rst_n = 1'b1;
    for (int c = 0; c < NR; c++) begin
      wr(0, 5'(c), 32'hFFFF_FFFF);
      wr(1, 5'(31 - c), 32'hFFFF_FFFF);
      iss(5'(c));
      rd(1, 5'(c));
      #1;
      chk($sformatf("init_ready_c%0d", c), 32'(bus_b.ready), 32'd0);
      if (c == 20) begin
        chk("init_rdata_zero", rdat(0, 1), 32'd0);
        chk("init_rbusy_zero", 32'(bus_b.rbusy), 32'd0);
      end
      tick();
    end
    idle();
    chk("init_ready_c32_b", 32'(bus_b.ready), 32'd1);
    chk("init_ready_c32_n", 32'(bus_n.ready), 32'd1);

    for (int r = 1; r < NR; r++) begin
      rd(0, 5'(r));
      rd(1, 5'(r));
      #1;
      chk($sformatf("clean_b0_x%0d", r), rdat(0, 0), 32'd0);
      chk($sformatf("clean_b1_x%0d", r), rdat(0, 1), 32'd0);
      chk($sformatf("clean_n0_x%0d", r), rdat(1, 0), 32'd0);
      chk($sformatf("clean_busy_x%0d", r), 32'(bus_b.rbusy), 32'd0);
    end

    wr(0, 5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    rd(0, 5'd5);
    #1;
    chk("wr_x5_b", rdat(0, 0), 32'hDEAD_BEEF);
    chk("wr_x5_n", rdat(1, 0), 32'hDEAD_BEEF);

    wr(0, 5'd0, 32'h1234_5678);
    rd(0, 5'd0);
    #1;
    chk("x0_bypass_b", rdat(0, 0), 32'd0);
    tick();
    idle();
    #1;
    chk("x0_after_b", rdat(0, 0), 32'd0);
    chk("x0_after_n", rdat(1, 0), 32'd0);

    wr(0, 5'd7, 32'h1111_1111);
    tick();
    idle();
    wr(0, 5'd7, 32'hAAAA_0000);
    wr(1, 5'd7, 32'h5555_FFFF);
    rd(1, 5'd7);
    #1;
    chk("dual_same_b", rdat(0, 1), 32'h5555_FFFF);
    chk("dual_same_n", rdat(1, 1), 32'h1111_1111);
    tick();
    idle();
    #1;
    chk("dual_next_b", rdat(0, 1), 32'h5555_FFFF);
    chk("dual_next_n", rdat(1, 1), 32'h5555_FFFF);
    wr(0, 5'd7, 32'h0BAD_F00D);
    #1;
    chk("byp_p0_b", rdat(0, 1), 32'h0BAD_F00D);
    chk("byp_p0_n", rdat(1, 1), 32'h5555_FFFF);
    tick();
    idle();

    rd(0, 5'd9);
    iss(5'd9);
    #1;
    chk("sb_iss_same", 32'(bus_b.rbusy[0]), 32'd0);
    tick();
    idle();
    #1;
    chk("sb_iss_next_b", 32'(bus_b.rbusy[0]), 32'd1);
    chk("sb_iss_next_n", 32'(bus_n.rbusy[0]), 32'd1);
    wr(0, 5'd9, 32'h0000_0099);
    #1;
    chk("sb_wb_same", 32'(bus_b.rbusy[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("sb_wb_next", 32'(bus_b.rbusy[0]), 32'd0);
    iss(5'd9);
    tick();
    idle();
    iss(5'd9);
    wr(1, 5'd9, 32'h0000_0009);
    tick();
    idle();
    #1;
    chk("sb_set_wins", 32'(bus_b.rbusy[0]), 32'd1);
    wr(0, 5'd9, 32'h0000_0019);
    tick();
    idle();
    #1;
    chk("sb_clr_again", 32'(bus_b.rbusy[0]), 32'd0);
    iss(5'd0);
    rd(0, 5'd0);
    tick();
    idle();
    #1;
    chk("sb_x0_never", 32'(bus_b.rbusy[0]), 32'd0);

    wr(0, 5'd3, 32'hCAFE_F00D);
    tick();
    idle();
    iss(5'd3);
    tick();
    idle();
    rd(0, 5'd3);
    rd(1, 5'd3);
    #1;
    chk("pre_clr_data", rdat(0, 0), 32'hCAFE_F00D);
    chk("pre_clr_busy", 32'(bus_b.rbusy), 32'd3);
    bus_b.clr_req = 1'b1;
    wr(0, 5'd3, 32'h1234_5678);
    #1;
    chk("clr_cycle_ready", 32'(bus_b.ready), 32'd1);
    chk("clr_cycle_nobyp", rdat(0, 0), 32'hCAFE_F00D);
    tick();
    idle();
    sweep_check("clr");
    chk("post_clr_b", rdat(0, 0), 32'd0);
    chk("post_clr_n", rdat(1, 1), 32'd0);
    chk("post_clr_busy", 32'(bus_b.rbusy), 32'd0);

    bus_b.clr_req = 1'b1;
    tick();
    idle();
    repeat (5) tick();
    bus_b.clr_req = 1'b1;
    tick();
    idle();
    sweep_check("clr_restart");

    bus_b.clr_req = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus_b.ready), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    sweep_check("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
